axi_read_master_if: RTL and testbench



---
 rtl/axi_read_master_if.sv | 135 +++++++++++++
 tb/tb_axi_read_master_if.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/axi_read_master_if.sv
// Single-beat AXI4 read master: turns a hold-until-done core read into one AR/R exchange.
// Optional watchdog on a hung slave is enabled by defining RD_TIMEOUT_EN.
module axi_read_master_if #(
    parameter logic [3:0] MASTER_ID      = 4'd0,
    parameter int         ADDR_W         = 32,
    parameter int         DATA_W         = 32,
    parameter int         TIMEOUT_CYCLES = 255
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic              req,
    input  logic [ADDR_W-1:0] req_addr,
    output logic [DATA_W-1:0] rdata,
    output logic              done,
    output logic              err,
    output logic              stall,
    output logic [3:0]        ARID,
    output logic [ADDR_W-1:0] ARADDR,
    output logic [3:0]        ARLEN,
    output logic [2:0]        ARSIZE,
    output logic [1:0]        ARBURST,
    output logic              ARVALID,
    input  logic              ARREADY,
    input  logic [3:0]        RID,
    input  logic [DATA_W-1:0] RDATA,
    input  logic [1:0]        RRESP,
    input  logic              RLAST,
    input  logic              RVALID,
    output logic              RREADY
);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_t;

    state_t state_reg;
    logic   captured_reg;

    assign ARID    = MASTER_ID;
    assign ARLEN   = 4'd0;
    assign ARSIZE  = 3'b010;
    assign ARBURST = 2'b01;
    assign stall   = req & ~done;

    // Only word-aligned addresses and the error bit of RRESP matter here.
    logic unused_bits;
    assign unused_bits = ^{RRESP[0], req_addr[1:0]};

`ifdef RD_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [TMO_W-1:0] tmo_cnt_reg;
    logic             busy;
    logic             handshake;
    logic             tmo_hit;

    assign busy      = (state_reg == S_ADDR) || (state_reg == S_DATA);
    assign handshake = ((state_reg == S_ADDR) && ARREADY) || ((state_reg == S_DATA) && RVALID);
    // Fires on the TIMEOUT_CYCLES-th consecutive cycle without a handshake.
    assign tmo_hit   = busy && !handshake && (tmo_cnt_reg == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    localparam int tmo_unused = TIMEOUT_CYCLES;
`endif

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_reg    <= S_IDLE;
            ARVALID      <= 1'b0;
            RREADY       <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            rdata        <= '0;
            ARADDR       <= '0;
            captured_reg <= 1'b0;
`ifdef RD_TIMEOUT_EN
            tmo_cnt_reg  <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (req) begin
                        ARADDR       <= {req_addr[ADDR_W-1:2], 2'b00};
                        ARVALID      <= 1'b1;
                        err          <= 1'b0;
                        captured_reg <= 1'b0;
                        state_reg    <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (ARREADY) begin
                        ARVALID   <= 1'b0;
                        RREADY    <= 1'b1;
                        state_reg <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (RVALID) begin
                        // Foreign-ID beats and extra beats are accepted but never overwrite rdata.
                        if (RID == MASTER_ID) begin
                            if (!captured_reg) begin
                                rdata        <= RDATA;
                                captured_reg <= 1'b1;
                            end
                            err <= RRESP[1];
                        end
                        if (RLAST) begin
                            RREADY    <= 1'b0;
                            done      <= 1'b1;
                            state_reg <= S_DONE;
                        end
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
`ifdef RD_TIMEOUT_EN
            if (tmo_hit) begin
                // Dropping ARVALID mid-handshake is intentional: recovery beats protocol here.
                ARVALID     <= 1'b0;
                RREADY      <= 1'b0;
                rdata       <= '0;
                err         <= 1'b1;
                done        <= 1'b1;
                state_reg   <= S_DONE;
                tmo_cnt_reg <= '0;
            end else if (busy && !handshake) begin
                tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
            end else begin
                tmo_cnt_reg <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_axi_read_master_if.sv
// Directed scoreboard bench for axi_read_master_if; expected completions are queued at request time.
module tb_axi_read_master_if;

    localparam logic [3:0] MID = 4'd0;

    logic        clk = 1'b0;
    logic        ARESETn;
    logic        req;
    logic [31:0] req_addr;
    logic [31:0] rdata;
    logic        done, err, stall;
    logic [3:0]  ARID;
    logic [31:0] ARADDR;
    logic [3:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic        ARVALID, ARREADY;
    logic [3:0]  RID;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST, RVALID, RREADY;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int done_cnt = 0;
    int last_done_cyc = 0;
    logic [32:0] sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    axi_read_master_if #(
        .MASTER_ID(MID), .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)
    ) dut (
        .ACLK(clk), .ARESETn(ARESETn), .req(req), .req_addr(req_addr),
        .rdata(rdata), .done(done), .err(err), .stall(stall),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
        .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
        .RVALID(RVALID), .RREADY(RREADY)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Completion monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            logic [32:0] e;
            done_cnt++;
            last_done_cyc = cyc;
            if (sb.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check("sb_rdata", 64'(rdata), 64'(e[31:0]));
                check("sb_err", 64'(err), 64'(e[32]));
                $display("txn: done at cycle %0d rdata=%08h err=%0b", cyc, rdata, err);
            end
        end
    end

    task automatic do_read(input logic [31:0] addr, input int ar_wait, input int r_wait,
                           input logic [31:0] data, input logic [1:0] resp, input int exp_lat,
                           input string tag);
        int start_cnt;
        int req_cyc;
        logic [31:0] exp_addr;
        exp_addr  = {addr[31:2], 2'b00};
        start_cnt = done_cnt;
        sb.push_back({resp[1], data});
        req = 1'b1; req_addr = addr; ARREADY = 1'b0; RVALID = 1'b0;
        req_cyc = cyc;
        step();
        req_addr = ~addr;
        check({tag, "_arvalid"}, 64'(ARVALID), 64'd1);
        check({tag, "_araddr"}, 64'(ARADDR), 64'(exp_addr));
        check({tag, "_stall_busy"}, 64'(stall), 64'd1);
        for (int i = 0; i < ar_wait; i++) begin
            step();
            check({tag, "_arvalid_hold"}, 64'(ARVALID), 64'd1);
            check({tag, "_araddr_hold"}, 64'(ARADDR), 64'(exp_addr));
        end
        ARREADY = 1'b1;
        step();
        ARREADY = 1'b0;
        check({tag, "_rready"}, 64'(RREADY), 64'd1);
        check({tag, "_arvalid_drop"}, 64'(ARVALID), 64'd0);
        for (int i = 0; i < r_wait; i++) begin
            step();
            check({tag, "_rready_hold"}, 64'(RREADY), 64'd1);
            check({tag, "_no_early_done"}, 64'(done), 64'd0);
        end
        RVALID = 1'b1; RLAST = 1'b1; RID = MID; RDATA = data; RRESP = resp;
        step();
        RVALID = 1'b0; RLAST = 1'b0;
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_stall_done"}, 64'(stall), 64'd0);
        req = 1'b0;
        step();
        check({tag, "_done_pulse"}, 64'(done), 64'd0);
        check({tag, "_done_once"}, 64'(done_cnt - start_cnt), 64'd1);
        check({tag, "_latency"}, 64'(last_done_cyc - req_cyc), 64'(exp_lat));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int start_cnt;
        ARESETn = 1'b0; req = 1'b0; req_addr = '0; ARREADY = 1'b0;
        RID = '0; RDATA = '0; RRESP = '0; RLAST = 1'b0; RVALID = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_arvalid", 64'(ARVALID), 64'd0);
        check("rst_rready", 64'(RREADY), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_rdata", 64'(rdata), 64'd0);
        check("rst_araddr", 64'(ARADDR), 64'd0);
        ARESETn = 1'b1;
        step();

        do_read(32'h0000_1006, 0, 0, 32'hDEADBEEF, 2'b00, 3, "zero_wait");
        check("const_arid", 64'(ARID), 64'(MID));
        check("const_arlen", 64'(ARLEN), 64'd0);
        check("const_arsize", 64'(ARSIZE), 64'd2);
        check("const_arburst", 64'(ARBURST), 64'd1);

        do_read(32'h0000_2003, 4, 5, 32'hCAFEF00D, 2'b00, 12, "backpressure");

        do_read(32'h0000_3000, 0, 0, 32'h12345678, 2'b10, 3, "err_resp");
        check("err_held", 64'(err), 64'd1);
        do_read(32'h0000_3004, 0, 0, 32'h0BADCAFE, 2'b00, 3, "err_clear");

        // Foreign-ID beat, matching beat, then a trailing extra beat that must not overwrite.
        start_cnt = done_cnt;
        sb.push_back({1'b0, 32'hA5A5A5A5});
        req = 1'b1; req_addr = 32'h0000_4000;
        step();
        ARREADY = 1'b1;
        step();
        ARREADY = 1'b0;
        RVALID = 1'b1; RID = MID + 4'd1; RLAST = 1'b0; RDATA = 32'h11111111; RRESP = 2'b10;
        step();
        RID = MID; RDATA = 32'hA5A5A5A5; RRESP = 2'b00;
        step();
        check("idmis_no_done", 64'(done), 64'd0);
        RDATA = 32'hFFFFFFFF; RLAST = 1'b1;
        step();
        RVALID = 1'b0; RLAST = 1'b0;
        check("idmis_done", 64'(done), 64'd1);
        req = 1'b0;
        step();
        check("idmis_done_once", 64'(done_cnt - start_cnt), 64'd1);

        // Reset in the middle of the data phase abandons the read.
        start_cnt = done_cnt;
        req = 1'b1; req_addr = 32'h0000_5000;
        step();
        ARREADY = 1'b1;
        step();
        ARREADY = 1'b0;
        check("midrst_rready_pre", 64'(RREADY), 64'd1);
        #2;
        ARESETn = 1'b0;
        #1;
        check("midrst_rready", 64'(RREADY), 64'd0);
        check("midrst_rdata", 64'(rdata), 64'd0);
        req = 1'b0;
        step();
        step();
        ARESETn = 1'b1;
        step();
        step();
        check("midrst_no_done", 64'(done_cnt - start_cnt), 64'd0);

`ifdef RD_TIMEOUT_EN
        begin
            int req_cyc;
            sb.push_back({1'b1, 32'h0});
            req = 1'b1; req_addr = 32'h0000_6000; ARREADY = 1'b0;
            req_cyc = cyc;
            step();
            for (int i = 0; i < 16; i++) step();
            check("tmo_done", 64'(done), 64'd1);
            check("tmo_arvalid", 64'(ARVALID), 64'd0);
            req = 1'b0;
            step();
            check("tmo_latency", 64'(last_done_cyc - req_cyc), 64'd17);
        end
`endif

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
